// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution stage: ARM condition codes,
// flag bit positions and FlagW write-enable bit positions.
package cond_pkg;

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;
  localparam logic [3:0] CS = 4'b0010;
  localparam logic [3:0] CC = 4'b0011;
  localparam logic [3:0] MI = 4'b0100;
  localparam logic [3:0] PL = 4'b0101;
  localparam logic [3:0] VS = 4'b0110;
  localparam logic [3:0] VC = 4'b0111;
  localparam logic [3:0] HI = 4'b1000;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] LE = 4'b1101;
  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;

  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned C = 1;
  localparam int unsigned V = 0;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder-to-condition-stage bundle. squash_cnt/squash_clr exist only when
// COND_STATS_EN is defined.
interface cond_logic_if;
  logic       en;
  logic       valid;
  logic [3:0] cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic       ex_valid;
  logic [3:0] flags;
`ifdef COND_STATS_EN
  logic [15:0] squash_cnt;
  logic        squash_clr;
`endif

  modport master (
    output en, valid, cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
`ifdef COND_STATS_EN
    output squash_clr,
    input  squash_cnt,
`endif
    input  PCSrc, RegWrite, MemWrite, CondEx, ex_valid, flags
  );

  modport slave (
    input  en, valid, cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
`ifdef COND_STATS_EN
    input  squash_clr,
    output squash_cnt,
`endif
    output PCSrc, RegWrite, MemWrite, CondEx, ex_valid, flags
  );
endinterface

// File: rtl/conditionals.sv
// Combinational ARM condition-code evaluator: cond field against {N,Z,C,V}.
// NV never executes.
module conditionals
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ok_o
);

  logic n, z, c, v, ge;

  assign n  = flags_i[N];
  assign z  = flags_i[Z];
  assign c  = flags_i[C];
  assign v  = flags_i[V];
  assign ge = (n == v);

  always_comb begin
    cond_ok_o = 1'b0;
    case (cond_i)
      EQ: cond_ok_o = z;
      NE: cond_ok_o = ~z;
      CS: cond_ok_o = c;
      CC: cond_ok_o = ~c;
      MI: cond_ok_o = n;
      PL: cond_ok_o = ~n;
      VS: cond_ok_o = v;
      VC: cond_ok_o = ~v;
      HI: cond_ok_o = c & ~z;
      LS: cond_ok_o = ~(c & ~z);
      GE: cond_ok_o = ge;
      LT: cond_ok_o = ~ge;
      GT: cond_ok_o = ~z & ge;
      LE: cond_ok_o = z | ~ge;
      AL: cond_ok_o = 1'b1;
      NV: cond_ok_o = 1'b0;
      default: cond_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: gates decoder controls by the condition result
// and owns the architectural flags. COND_STATS_EN adds a squash counter.
module cond_logic
  import cond_pkg::*;
(
  input logic         clk,
  input logic         reset,
  cond_logic_if.slave bus
);

  logic       cond_ok;
  logic       accept;
  logic       ex_valid_q, cond_ex_q, pc_src_q, reg_write_q, mem_write_q;
  logic [3:0] flags_q, flags_d;

  // Evaluated against registered flags so back-to-back instructions see the
  // previous instruction's flag write without a bubble.
  conditionals u_conditionals (
    .cond_i    (bus.cond),
    .flags_i   (flags_q),
    .cond_ok_o (cond_ok)
  );

  assign accept = bus.en & bus.valid;

  always_comb begin
    flags_d = flags_q;
    if (accept && cond_ok) begin
      if (bus.FlagW[FLAGW_NZ]) flags_d[N:Z] = bus.ALUFlags[N:Z];
      if (bus.FlagW[FLAGW_CV]) flags_d[C:V] = bus.ALUFlags[C:V];
    end
  end

  // Stalls and bubbles load zeros so a held instruction never writes twice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q  <= 1'b0;
      cond_ex_q   <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      ex_valid_q  <= accept;
      cond_ex_q   <= accept & cond_ok;
      pc_src_q    <= accept & cond_ok & bus.PCS;
      reg_write_q <= accept & cond_ok & bus.RegW & ~bus.NoWrite;
      mem_write_q <= accept & cond_ok & bus.MemW;
      flags_q     <= flags_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.CondEx   = cond_ex_q;
  assign bus.PCSrc    = pc_src_q;
  assign bus.RegWrite = reg_write_q;
  assign bus.MemWrite = mem_write_q;
  assign bus.flags    = flags_q;

`ifdef COND_STATS_EN
  logic [15:0] squash_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash_cnt_q <= 16'h0000;
    end else if (bus.squash_clr) begin
      squash_cnt_q <= 16'h0000;
    end else if (accept && !cond_ok && squash_cnt_q != 16'hFFFF) begin
      squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end

  assign bus.squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: vector table plus reset and counter sequences.
module tb_cond_logic;
  import cond_pkg::*;

  typedef struct packed {
    logic       en;
    logic       valid;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       nowrite;
    logic       e_condex;
    logic       e_pcsrc;
    logic       e_regwrite;
    logic       e_memwrite;
    logic       e_exvalid;
    logic [3:0] e_flags;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  vec_t vecs[$];

  cond_logic_if bus ();

  cond_logic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic condex, input logic pcsrc,
                          input logic regwrite, input logic memwrite, input logic exvalid,
                          input logic [3:0] flg);
    chk({tag, ".CondEx"},   {15'd0, bus.CondEx},   {15'd0, condex});
    chk({tag, ".PCSrc"},    {15'd0, bus.PCSrc},    {15'd0, pcsrc});
    chk({tag, ".RegWrite"}, {15'd0, bus.RegWrite}, {15'd0, regwrite});
    chk({tag, ".MemWrite"}, {15'd0, bus.MemWrite}, {15'd0, memwrite});
    chk({tag, ".ex_valid"}, {15'd0, bus.ex_valid}, {15'd0, exvalid});
    chk({tag, ".flags"},    {12'd0, bus.flags},    {12'd0, flg});
  endtask

  task automatic drive(input logic en, input logic valid, input logic [3:0] cond,
                       input logic [3:0] alu, input logic [1:0] flagw, input logic pcs,
                       input logic regw, input logic memw, input logic nowrite);
    bus.en       = en;
    bus.valid    = valid;
    bus.cond     = cond;
    bus.ALUFlags = alu;
    bus.FlagW    = flagw;
    bus.PCS      = pcs;
    bus.RegW     = regw;
    bus.MemW     = memw;
    bus.NoWrite  = nowrite;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef COND_STATS_EN
    bus.squash_clr = 1'b0;
`endif

    // en valid cond alu flagw pcs regw memw nw | condex pcsrc regwr memwr exv flags
    vecs.push_back({1'b1,1'b1,EQ,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b0000});
    vecs.push_back({1'b1,1'b1,AL,4'b0100,2'b11,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,4'b0100});
    vecs.push_back({1'b1,1'b1,EQ,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1,4'b0100});
    vecs.push_back({1'b1,1'b1,NE,4'b0000,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b0100});
    vecs.push_back({1'b1,1'b1,NE,4'b1011,2'b11,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b0100});
    vecs.push_back({1'b1,1'b1,AL,4'b0000,2'b11,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,4'b0000});
    vecs.push_back({1'b1,1'b1,AL,4'b1011,2'b10,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,4'b1000});
    vecs.push_back({1'b1,1'b1,AL,4'b0011,2'b01,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,GE,4'b0000,2'b00,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,LT,4'b0000,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,HI,4'b0000,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,LS,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,GT,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,LE,4'b0000,2'b00,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,MI,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,PL,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,CS,4'b0000,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,CC,4'b0000,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,VS,4'b0000,2'b00,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,VC,4'b0000,2'b00,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,NV,4'b0000,2'b11,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b0,1'b1,AL,4'b0000,2'b11,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'b1011});
    vecs.push_back({1'b1,1'b0,AL,4'b0000,2'b11,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,4'b1011});
    vecs.push_back({1'b1,1'b1,AL,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1,4'b1011});
    vecs.push_back({1'b1,1'b1,AL,4'b0000,2'b00,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b1,4'b1011});

    // Reset state, held across a clock edge.
    #12;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
`ifdef COND_STATS_EN
    chk("reset.squash_cnt", bus.squash_cnt, 16'h0000);
`endif
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].valid, vecs[i].cond, vecs[i].alu, vecs[i].flagw,
            vecs[i].pcs, vecs[i].regw, vecs[i].memw, vecs[i].nowrite);
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_condex, vecs[i].e_pcsrc,
               vecs[i].e_regwrite, vecs[i].e_memwrite, vecs[i].e_exvalid, vecs[i].e_flags);
    end

    // Asynchronous reset with live outputs: clears without a clock edge.
    drive(1'b0, 1'b0, AL, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    #1;
    reset = 1'b1;
    // PL passes only if flags were really cleared (N was 1 before reset).
    drive(1'b1, 1'b1, PL, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_outs("post_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);

`ifdef COND_STATS_EN
    // flags are 0000, so EQ always fails and counts as a squash.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, EQ, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    chk("squash3", bus.squash_cnt, 16'd3);
    drive(1'b0, 1'b1, EQ, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("squash_stall", bus.squash_cnt, 16'd3);
    drive(1'b1, 1'b1, EQ, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 65532; k++) step();
    chk("squash_max", bus.squash_cnt, 16'hFFFF);
    step();
    chk("squash_sat", bus.squash_cnt, 16'hFFFF);
    bus.squash_clr = 1'b1;
    step();
    chk("squash_clr", bus.squash_cnt, 16'h0000);
    bus.squash_clr = 1'b0;
    step();
    chk("squash_after_clr", bus.squash_cnt, 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
